// File: rtl/gray_ptr_sync_pkg.sv
// Shared constants and helpers for the Gray pointer synchroniser.
// Helpers operate on a PTR_W_MAX-wide vector; callers zero-extend their PTR_W pointer.
package gray_ptr_sync_pkg;

  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;
  localparam int PTR_W_MAX  = 16;

  // Zero-extension is harmless: upper zero bits leave the prefix-XOR of lower bits unchanged.
  function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
    logic [PTR_W_MAX-1:0] b;
    b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic popcount_gt1(input logic [PTR_W_MAX-1:0] v);
    return (v & (v - PTR_W_MAX'(1))) != '0;
  endfunction

endpackage

// File: rtl/gray_ptr_sync_sync_chain.sv
// Plain PTR_W x STAGES flop chain for crossing a Gray pointer into the destination clock.
// No logic between stages; flops are tagged for ASYNC_REG placement.
module gray_ptr_sync_sync_chain #(
  parameter int PTR_W  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [PTR_W-1:0] d_i,
  output logic [PTR_W-1:0] q_o
);

  (* ASYNC_REG = "TRUE" *) logic [PTR_W-1:0] s_q [STAGES];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < STAGES; i++) begin
        s_q[i] <= '0;
      end
    end else begin
      s_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        s_q[i] <= s_q[i-1];
      end
    end
  end

  assign q_o = s_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Multi-stage Gray pointer synchroniser with registered binary output and update strobe.
// Optional multi-bit-step checker compiled in when GRAY_PTR_SYNC_CHK_EN is defined.
module gray_ptr_sync
  import gray_ptr_sync_pkg::*;
#(
  parameter int PTR_W     = 8,
  parameter int STAGES    = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 wrt_clk,
  input  logic                 wrt_rst_n,
  input  logic [PTR_W-1:0]     rd_ptr,
  input  logic                 err_clr,
  output logic [PTR_W-1:0]     wq_rd_ptr,
  output logic [PTR_W-1:0]     wq_rd_ptr_bin,
  output logic                 ptr_upd,
  output logic                 gray_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("gray_ptr_sync: STAGES must be within %0d..%0d", STAGES_MIN, STAGES_MAX);
  end
  if (PTR_W < 2 || PTR_W > PTR_W_MAX) begin : g_bad_width
    $error("gray_ptr_sync: PTR_W must be within 2..%0d", PTR_W_MAX);
  end

  logic [PTR_W-1:0] prev_q;
  logic [PTR_W-1:0] bin_q, bin_d;
  logic             upd_q, upd_d;

  gray_ptr_sync_sync_chain #(
    .PTR_W  (PTR_W),
    .STAGES (STAGES)
  ) u_sync_chain (
    .clk_i   (wrt_clk),
    .rst_n_i (wrt_rst_n),
    .d_i     (rd_ptr),
    .q_o     (wq_rd_ptr)
  );

  always_comb begin
    bin_d = PTR_W'(gray2bin(PTR_W_MAX'(wq_rd_ptr)));
    upd_d = (wq_rd_ptr != prev_q);
  end

  always_ff @(posedge wrt_clk or negedge wrt_rst_n) begin
    if (!wrt_rst_n) begin
      prev_q <= '0;
      bin_q  <= '0;
      upd_q  <= 1'b0;
    end else begin
      prev_q <= wq_rd_ptr;
      bin_q  <= bin_d;
      upd_q  <= upd_d;
    end
  end

  assign wq_rd_ptr_bin = bin_q;
  assign ptr_upd       = upd_q;

`ifdef GRAY_PTR_SYNC_CHK_EN
  logic                 bad_step;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  // A bad step outranks a coincident clear so the event is never lost.
  always_comb begin
    bad_step = popcount_gt1(PTR_W_MAX'(wq_rd_ptr ^ prev_q));
    err_d    = err_q;
    cnt_d    = cnt_q;
    if (bad_step) begin
      err_d = 1'b1;
      if (err_clr) begin
        cnt_d = ERR_CNT_W'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + ERR_CNT_W'(1);
      end
    end else if (err_clr) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge wrt_clk or negedge wrt_rst_n) begin
    if (!wrt_rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign gray_err = err_q;
  assign err_cnt  = cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign gray_err       = 1'b0;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Scoreboard bench for gray_ptr_sync (PTR_W=8, STAGES=3, ERR_CNT_W=2).
module tb_gray_ptr_sync;

  localparam int PW   = 8;
  localparam int ST   = 3;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
`ifdef GRAY_PTR_SYNC_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [PW-1:0] gray;
    logic [PW-1:0] bin;
    logic          upd;
    logic          bad;
  } exp_t;

  logic          wrt_clk;
  logic          wrt_rst_n;
  logic [PW-1:0] rd_ptr;
  logic          err_clr;
  logic [PW-1:0] wq_rd_ptr;
  logic [PW-1:0] wq_rd_ptr_bin;
  logic          ptr_upd;
  logic          gray_err;
  logic [CW-1:0] err_cnt;

  exp_t          sb_q[$];
  logic [PW-1:0] m_prev;
  logic          m_err;
  int            m_cnt;
  int            tests_run;
  int            failed;
  int            upd_seen;

  gray_ptr_sync #(
    .PTR_W     (PW),
    .STAGES    (ST),
    .ERR_CNT_W (CW)
  ) dut (
    .wrt_clk       (wrt_clk),
    .wrt_rst_n     (wrt_rst_n),
    .rd_ptr        (rd_ptr),
    .err_clr       (err_clr),
    .wq_rd_ptr     (wq_rd_ptr),
    .wq_rd_ptr_bin (wq_rd_ptr_bin),
    .ptr_upd       (ptr_upd),
    .gray_err      (gray_err),
    .err_cnt       (err_cnt)
  );

  initial wrt_clk = 1'b0;
  always #5 wrt_clk = ~wrt_clk;

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int s = 1; s < PW; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [PW-1:0] b2g(input int unsigned b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  // Chain and post stage hold zero after reset; seed the queue to match.
  task automatic sb_reset();
    exp_t z;
    z.gray = '0; z.bin = '0; z.upd = 1'b0; z.bad = 1'b0;
    sb_q.delete();
    for (int i = 0; i < ST; i++) sb_q.push_back(z);
    m_prev = '0;
    m_err  = 1'b0;
    m_cnt  = 0;
  endtask

  // Called at a falling edge; drives one sample, checks after the rising edge, returns at the next falling edge.
  task automatic step(input logic [PW-1:0] g, input logic clr);
    exp_t e, o;
    rd_ptr  = g;
    err_clr = clr;
    e.gray  = g;
    e.bin   = g2b(g);
    e.upd   = (g != m_prev);
    e.bad   = ($countones(g ^ m_prev) > 1);
    m_prev  = g;
    sb_q.push_back(e);
    @(posedge wrt_clk);
    #1;
    o = sb_q.pop_front();
    if (CHK) begin
      if (o.bad) begin
        m_err = 1'b1;
        if (clr) m_cnt = 1;
        else if (m_cnt < CMAX) m_cnt = m_cnt + 1;
      end else if (clr) begin
        m_err = 1'b0;
        m_cnt = 0;
      end
    end
    tests_run++;
    if (wq_rd_ptr !== sb_q[0].gray) begin
      failed++;
      $display("FAIL sb_wq_rd_ptr t=%0t actual=%h required=%h", $time, wq_rd_ptr, sb_q[0].gray);
    end
    tests_run++;
    if (wq_rd_ptr_bin !== o.bin) begin
      failed++;
      $display("FAIL sb_bin t=%0t actual=%h required=%h", $time, wq_rd_ptr_bin, o.bin);
    end
    tests_run++;
    if (ptr_upd !== o.upd) begin
      failed++;
      $display("FAIL sb_ptr_upd t=%0t actual=%b required=%b", $time, ptr_upd, o.upd);
    end
    tests_run++;
    if (gray_err !== m_err) begin
      failed++;
      $display("FAIL sb_gray_err t=%0t actual=%b required=%b", $time, gray_err, m_err);
    end
    tests_run++;
    if (err_cnt !== CW'(m_cnt)) begin
      failed++;
      $display("FAIL sb_err_cnt t=%0t actual=%0d required=%0d", $time, err_cnt, m_cnt);
    end
    if (ptr_upd === 1'b1) upd_seen++;
    @(negedge wrt_clk);
  endtask

  task automatic do_reset();
    wrt_rst_n = 1'b0;
    rd_ptr    = '0;
    err_clr   = 1'b0;
    @(negedge wrt_clk);
    @(negedge wrt_clk);
    wrt_rst_n = 1'b1;
    sb_reset();
  endtask

  task automatic test_reset();
    wrt_rst_n = 1'b0;
    rd_ptr    = '0;
    err_clr   = 1'b0;
    #1;
    tests_run++;
    if ({wq_rd_ptr, wq_rd_ptr_bin, ptr_upd, gray_err, err_cnt} !== '0) begin
      failed++;
      $display("FAIL reset_outputs actual=%h/%h/%b/%b/%0d required=0", wq_rd_ptr, wq_rd_ptr_bin, ptr_upd, gray_err, err_cnt);
    end
    @(negedge wrt_clk);
    wrt_rst_n = 1'b1;
    sb_reset();
    upd_seen = 0;
    repeat (10) step('0, 1'b0);
    tests_run++;
    if (upd_seen != 0) begin
      failed++;
      $display("FAIL reset_no_upd actual=%0d required=0", upd_seen);
    end
  endtask

  task automatic test_single_step();
    int lat_wq, lat_upd;
    lat_wq  = 0;
    lat_upd = 0;
    step('0, 1'b0);
    for (int n = 1; n <= 10; n++) begin
      step(8'h01, 1'b0);
      if (wq_rd_ptr === 8'h01 && lat_wq == 0) lat_wq = n;
      if (ptr_upd === 1'b1 && lat_upd == 0) lat_upd = n;
    end
    tests_run++;
    if (lat_wq != ST) begin
      failed++;
      $display("FAIL step_wq_latency actual=%0d required=%0d", lat_wq, ST);
    end
    tests_run++;
    if (lat_upd != ST + 1) begin
      failed++;
      $display("FAIL step_upd_latency actual=%0d required=%0d", lat_upd, ST + 1);
    end
  endtask

  task automatic test_walk();
    upd_seen = 0;
    for (int i = 1; i <= 300; i++) step(b2g((1 + i) & 255), 1'b0);
    repeat (ST + 1) step(b2g(301 & 255), 1'b0);
    tests_run++;
    if (upd_seen != 300) begin
      failed++;
      $display("FAIL walk_upd_pulses actual=%0d required=300", upd_seen);
    end
    tests_run++;
    if (wq_rd_ptr_bin !== PW'(301 & 255) || gray_err !== 1'b0) begin
      failed++;
      $display("FAIL walk_final actual=%h/%b required=%h/0", wq_rd_ptr_bin, gray_err, PW'(301 & 255));
    end
  endtask

  task automatic test_errors();
    do_reset();
    repeat (2) step('0, 1'b0);
    step(8'h03, 1'b0);
    repeat (ST + 1) step(8'h03, 1'b0);
    tests_run++;
    if (gray_err !== CHK || err_cnt !== CW'(CHK)) begin
      failed++;
      $display("FAIL err_first actual=%b/%0d required=%b/%0d", gray_err, err_cnt, CHK, CHK);
    end
    // Second bad step reaches the checker ST edges after it is sampled; clear lands on that edge.
    step(8'h00, 1'b0);
    repeat (ST - 1) step(8'h00, 1'b0);
    step(8'h00, 1'b1);
    tests_run++;
    if (gray_err !== CHK || err_cnt !== CW'(CHK)) begin
      failed++;
      $display("FAIL err_clr_collide actual=%b/%0d required=%b/%0d", gray_err, err_cnt, CHK, CHK);
    end
    repeat (3) step(8'h00, 1'b0);
    step(8'h00, 1'b1);
    tests_run++;
    if (gray_err !== 1'b0 || err_cnt !== '0) begin
      failed++;
      $display("FAIL err_lone_clr actual=%b/%0d required=0/0", gray_err, err_cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    step('0, 1'b0);
    for (int i = 0; i < 5; i++) step((i % 2 == 0) ? 8'h03 : 8'h00, 1'b0);
    repeat (ST + 1) step(8'h03, 1'b0);
    tests_run++;
    if (err_cnt !== (CHK ? CW'(CMAX) : CW'(0)) || gray_err !== CHK) begin
      failed++;
      $display("FAIL sat_err_cnt actual=%0d/%b required=%0d/%b", err_cnt, gray_err, CHK ? CMAX : 0, CHK);
    end
  endtask

  task automatic test_reset_midwalk();
    bit found;
    int lat_upd;
    found   = 1'b0;
    lat_upd = 0;
    do_reset();
    for (int i = 1; i <= 100 && !found; i++) begin
      step(b2g(i), 1'b0);
      if (sb_q[0].gray == 8'h2A) found = 1'b1;
    end
    tests_run++;
    if (!found || wq_rd_ptr !== 8'h2A) begin
      failed++;
      $display("FAIL midwalk_reach actual=%h required=2a", wq_rd_ptr);
    end
    #2;
    wrt_rst_n = 1'b0;
    rd_ptr    = '0;
    #1;
    tests_run++;
    if ({wq_rd_ptr, wq_rd_ptr_bin, ptr_upd, gray_err, err_cnt} !== '0) begin
      failed++;
      $display("FAIL midwalk_async_reset actual=%h/%h/%b/%b/%0d required=0", wq_rd_ptr, wq_rd_ptr_bin, ptr_upd, gray_err, err_cnt);
    end
    @(negedge wrt_clk);
    @(negedge wrt_clk);
    wrt_rst_n = 1'b1;
    sb_reset();
    upd_seen = 0;
    repeat (3) step('0, 1'b0);
    tests_run++;
    if (upd_seen != 0) begin
      failed++;
      $display("FAIL midwalk_release_upd actual=%0d required=0", upd_seen);
    end
    for (int n = 1; n <= 10; n++) begin
      step(8'h01, 1'b0);
      if (ptr_upd === 1'b1 && lat_upd == 0) lat_upd = n;
    end
    tests_run++;
    if (lat_upd != ST + 1) begin
      failed++;
      $display("FAIL midwalk_upd_latency actual=%0d required=%0d", lat_upd, ST + 1);
    end
  endtask

  initial begin
    tests_run = 0;
    failed    = 0;
    upd_seen  = 0;
    test_reset();
    test_single_step();
    test_walk();
    test_errors();
    test_saturate();
    test_reset_midwalk();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
